instr_sequencer: RTL and testbench

Program sequencer that drives the `processor` datapath's `instruction` input from an on-chip program buffer, replacing hand-timed stimulus. Software or a bench loads a list of 32-bit RV64 instructions, pulses `start`, and the block issues each instruction for a fixed number of cycles. It captures the processor's `result` for each instruction and reports it on a result stream. It sits between a host/load port and the processor core.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/instr_sequencer_prog_buffer.sv | 22 ++
 rtl/instr_sequencer.sv | 108 ++++++++++
 tb/tb_instr_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV64 program sequencer and its neighbours.
package riscv_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {
    IDLE,
    ISSUE
  } seq_state_t;

endpackage

// File: rtl/instr_sequencer_prog_buffer.sv
// Program buffer: DEPTH x 32 RAM, synchronous write, asynchronous read.
module prog_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues a loaded list of instructions to the processor, holding each for
// HOLD_CYCLES cycles and capturing the processor result at the end of each hold.
module instr_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned XLEN        = riscv_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [31:0]              load_data,
  output logic                     load_ready,
  input  logic                     clear,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              instruction,
  input  logic [XLEN-1:0]          result_in,
  output logic                     res_valid,
  output logic [XLEN-1:0]          res_data,
  output logic [$clog2(DEPTH)-1:0] res_index
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES);

  seq_state_t    state;
  logic [AW-1:0] idx;
  logic [HW-1:0] hold;
  logic [31:0]   rd_word;
  logic          wr_en;
  logic          last_hold;
  logic          last_idx;

  assign busy        = (state == ISSUE);
  assign load_ready  = (state == IDLE) && (count < CW'(DEPTH));
  assign wr_en       = load_valid && load_ready && !clear;
  assign instruction = busy ? rd_word : NOP_INSTR;
  assign last_hold   = (hold == HW'(HOLD_CYCLES - 1));
  assign last_idx    = ((CW'(idx) + CW'(1)) == count);

  prog_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (count[AW-1:0]),
    .wdata (load_data),
    .raddr (idx),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      idx       <= '0;
      hold      <= '0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_index <= '0;
    end else begin
      done      <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clear)      count <= '0;
          else if (wr_en) count <= count + CW'(1);
          // A clear in the same cycle empties the program, so start then
          // behaves as an empty run.
          if (start) begin
            if ((count != '0) && !clear) begin
              state <= ISSUE;
              idx   <= '0;
              hold  <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (last_hold) begin
            res_data  <= result_in;
            res_index <= idx;
            res_valid <= 1'b1;
            if (last_idx) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              idx  <= idx + AW'(1);
              hold <= '0;
            end
          end else begin
            hold <= hold + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed/randomized bench for instr_sequencer with a small RV64 ALU stub
// standing in for the processor and a queue-based reference model.
module tb_instr_sequencer;

  localparam int unsigned D = 64;
  localparam int unsigned H = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [6:0]  count;
  logic [31:0] instruction;
  logic [63:0] result_in;
  logic        res_valid;
  logic [63:0] res_data;
  logic [5:0]  res_index;

  always #5 clk = ~clk;

  instr_sequencer #(
    .DEPTH       (D),
    .HOLD_CYCLES (H),
    .XLEN        (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .clear       (clear),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .instruction (instruction),
    .result_in   (result_in),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_index   (res_index)
  );

  // Processor stub: single-cycle addi/add with a register file; any other
  // opcode returns {instr, ~instr} and writes nothing.
  logic [63:0] xr [32];
  logic        alu_op;

  always_comb begin
    alu_op    = 1'b0;
    result_in = {instruction, ~instruction};
    if (instruction[6:0] == 7'h13 && instruction[14:12] == 3'd0) begin
      alu_op    = 1'b1;
      result_in = xr[instruction[19:15]] + {{52{instruction[31]}}, instruction[31:20]};
    end else if (instruction[6:0] == 7'h33 && instruction[14:12] == 3'd0 &&
                 instruction[31:25] == 7'd0) begin
      alu_op    = 1'b1;
      result_in = xr[instruction[19:15]] + xr[instruction[24:20]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < 32; r++) xr[r] <= '0;
    end else if (alu_op && instruction[11:7] != 5'd0) begin
      xr[instruction[11:7]] <= result_in;
    end
  end

  // Output monitor
  int          cyc = 0;
  int          done_cnt = 0;
  int          rv_idx [$];
  logic [63:0] rv_dat [$];
  int          rv_cyc [$];

  always @(negedge clk) begin
    cyc++;
    if (res_valid === 1'b1) begin
      rv_idx.push_back(int'(res_index));
      rv_dat.push_back(res_data);
      rv_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cnt++;
  end

  // Reference model
  logic [31:0] mbuf [$];
  logic [63:0] mreg [32];
  logic [63:0] prev_res [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) mreg[r] = '0;
  endtask

  task automatic ref_exec(input logic [31:0] w, output logic [63:0] r);
    logic alu;
    alu = 1'b0;
    r   = {w, ~w};
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
      alu = 1'b1;
      r   = mreg[w[19:15]] + {{52{w[31]}}, w[31:20]};
    end else if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'd0) begin
      alu = 1'b1;
      r   = mreg[w[19:15]] + mreg[w[24:20]];
    end
    if (alu && w[11:7] != 5'd0) mreg[w[11:7]] = r;
  endtask

  task automatic load_words(input logic [31:0] ws [$]);
    foreach (ws[i]) begin
      @(negedge clk);
      chk($sformatf("load_ready_w%0d", i), 64'(load_ready), 64'(mbuf.size() < D));
      load_valid = 1'b1;
      load_data  = ws[i];
      if (mbuf.size() < D) mbuf.push_back(ws[i]);
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic run_prog(input bit inject, input string tag);
    int          n, base_q, base_done;
    logic [63:0] exp_res [$];
    logic [63:0] r;
    n         = mbuf.size();
    base_q    = rv_idx.size();
    base_done = done_cnt;
    foreach (mbuf[i]) begin
      ref_exec(mbuf[i], r);
      exp_res.push_back(r);
    end
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      for (int h = 0; h < int'(H); h++) begin
        @(negedge clk);
        start = 1'b0;
        if (inject && i == 1 && h == 1) begin
          clear      = 1'b0;
          load_valid = 1'b0;
        end
        chk($sformatf("%s_instr_e%0d_h%0d", tag, i, h), 64'(instruction), 64'(mbuf[i]));
        chk($sformatf("%s_busy_e%0d_h%0d", tag, i, h), 64'(busy), 64'd1);
        if (inject && i == 1 && h == 0) begin
          start      = 1'b1;
          clear      = 1'b1;
          load_valid = 1'b1;
          load_data  = $urandom();
        end
      end
    end
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_last_valid"}, 64'(res_valid), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_instr_idle"}, 64'(instruction), 64'(NOP));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_valid_pulse"}, 64'(res_valid), 64'd0);
    chk({tag, "_count_kept"}, 64'(count), 64'(n));
    chk({tag, "_done_cnt"}, 64'(done_cnt - base_done), 64'd1);
    chk({tag, "_n_results"}, 64'(rv_idx.size() - base_q), 64'(n));
    if (rv_idx.size() - base_q == n) begin
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_res_index%0d", tag, i), 64'(rv_idx[base_q + i]), 64'(i));
        chk($sformatf("%s_res_data%0d", tag, i), rv_dat[base_q + i], exp_res[i]);
        if (i > 0)
          chk($sformatf("%s_spacing%0d", tag, i),
              64'(rv_cyc[base_q + i] - rv_cyc[base_q + i - 1]), 64'(H));
      end
    end
  endtask

  initial begin
    logic [31:0] prog3 [$];
    logic [31:0] rnd   [$];
    logic [31:0] w;
    int          base_q, base_done;

    prog3 = '{32'h00A00093, 32'h01408113, 32'h002081B3};
    model_reset();

    // Reset values
    reset = 1'b1;
    #12;
    chk("rst_instr", 64'(instruction), 64'(NOP));
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd1);
    chk("rst_res_data", res_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Three-instruction run with known results
    load_words(prog3);
    chk("p3_count", 64'(count), 64'd3);
    base_q = rv_idx.size();
    run_prog(1'b0, "p3");
    if (rv_dat.size() >= base_q + 3) begin
      chk("p3_const0", rv_dat[base_q], 64'h0a);
      chk("p3_const1", rv_dat[base_q + 1], 64'h1e);
      chk("p3_const2", rv_dat[base_q + 2], 64'h28);
    end

    // Empty start
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mbuf.delete();
    chk("empty_count", 64'(count), 64'd0);
    base_q    = rv_idx.size();
    base_done = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_busy", 64'(busy), 64'd0);
    chk("empty_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("empty_done_pulse", 64'(done), 64'd0);
    chk("empty_busy2", 64'(busy), 64'd0);
    chk("empty_no_results", 64'(rv_idx.size() - base_q), 64'd0);
    chk("empty_done_cnt", 64'(done_cnt - base_done), 64'd1);

    // Full buffer, including an extra offered word
    for (int i = 0; i < int'(D); i++) begin
      w = $urandom();
      w[6:0] = 7'h0B;
      rnd.push_back(w);
    end
    load_words(rnd);
    chk("full_load_ready", 64'(load_ready), 64'd0);
    chk("full_count", 64'(count), 64'(D));
    load_valid = 1'b1;
    load_data  = 32'hDEADBEEF;
    @(negedge clk);
    load_valid = 1'b0;
    chk("full_extra_count", 64'(count), 64'(D));
    base_q = rv_dat.size();
    run_prog(1'b0, "full");
    for (int i = 0; i < int'(D); i++)
      if (rv_dat.size() > base_q + i) prev_res.push_back(rv_dat[base_q + i]);

    // Ignored inputs mid-run, then a clean re-run
    run_prog(1'b1, "inj");
    base_q = rv_dat.size();
    run_prog(1'b0, "rerun");
    if (rv_dat.size() >= base_q + int'(D) && prev_res.size() == int'(D))
      for (int i = 0; i < int'(D); i++)
        chk($sformatf("rerun_same%0d", i), rv_dat[base_q + i], prev_res[i]);

    // Reset mid-run during entry 1's hold
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mbuf.delete();
    load_words(prog3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_instr", 64'(instruction), 64'(NOP));
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_valid", 64'(res_valid), 64'd0);
    chk("mid_res_data", res_data, 64'd0);
    chk("mid_res_index", 64'(res_index), 64'd0);
    chk("mid_load_ready", 64'(load_ready), 64'd1);
    base_q    = rv_idx.size();
    base_done = done_cnt;
    mbuf.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_no_results", 64'(rv_idx.size() - base_q), 64'd0);
    chk("mid_no_done", 64'(done_cnt - base_done), 64'd0);
    chk("mid_count_after", 64'(count), 64'd0);

    // Recovery after reset
    load_words(prog3);
    run_prog(1'b0, "post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
